// File: rtl/mul8_seq_ctrl.sv
// Sequential 8x8 -> 16 unsigned multiplier built from four passes through one
// shared 4x4 array multiplier, with optional accumulate onto the last result.

module array_multiplier (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] p
);
  logic [3:0][7:0] row;

  for (genvar i = 0; i < 4; i++) begin : g_row
    assign row[i] = y[i] ? ({4'b0, x} << i) : 8'h00;
  end

  assign p = row[0] + row[1] + row[2] + row[3];
endmodule

module mul8_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        acc_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        busy
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [1:0]  step_q, step_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] last_q, last_d;
  logic [15:0] result_q, result_d;

  logic [3:0]  mx, my;
  logic [7:0]  pp;
  logic [3:0]  shamt;
  logic [15:0] pp_sh, acc_sum;

  // step[0] picks the high nibble of a, step[1] the high nibble of b
  assign mx = step_q[0] ? a_q[7:4] : a_q[3:0];
  assign my = step_q[1] ? b_q[7:4] : b_q[3:0];

  array_multiplier u_mul (.x(mx), .y(my), .p(pp));

  always_comb begin
    case (step_q)
      2'd0:    shamt = 4'd0;
      2'd3:    shamt = 4'd8;
      default: shamt = 4'd4;
    endcase
  end

  assign pp_sh   = {8'h00, pp} << shamt;
  assign acc_sum = acc_q + pp_sh;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    step_d   = step_q;
    acc_d    = acc_q;
    last_d   = last_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = acc_en ? last_q : 16'h0000;
          step_d  = 2'd0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d  = acc_sum;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          result_d = acc_sum;
          last_d   = acc_sum;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      step_q   <= 2'd0;
      acc_q    <= 16'h0000;
      last_q   <= 16'h0000;
      result_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      step_q   <= step_d;
      acc_q    <= acc_d;
      last_q   <= last_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_CALC) || (state_q == S_DONE);
  assign result    = result_q;
endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Randomized bench for mul8_seq_ctrl against an arithmetic reference model
// (product plus optional previous result, modulo 2^16).

module tb_mul8_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a, b;
  logic        acc_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] last_m = 16'h0000;
  logic [15:0] res_m  = 16'h0000;

  always #5 clk = ~clk;

  mul8_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .acc_en(acc_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction: accept, 4 CALC cycles, `stall` cycles of backpressure, handoff.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tacc,
                        input int stall, input logic check_exp, input logic [15:0] exp_fixed);
    logic [15:0] exp;
    int cnt;
    exp = (tacc ? last_m : 16'h0000) + 16'(ta) * 16'(tb_);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    chk("busy_idle", busy, 0);
    a = ta; b = tb_; acc_en = tacc; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    cnt = 0;
    do begin
      // operand noise during CALC must be ignored
      in_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
      acc_en = 1'($urandom); out_ready = 1'($urandom);
      @(negedge clk);
      cnt++;
      if (!out_valid) begin
        chk("calc_in_ready", in_ready, 0);
        chk("calc_busy", busy, 1);
        chk("calc_result_hold", result, res_m);
      end
    end while (!out_valid && cnt < 20);
    chk("latency", cnt, 5);
    chk("result", result, exp);
    if (check_exp) chk("result_directed", result, exp_fixed);
    last_m = exp;
    res_m  = exp;
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom); acc_en = 1'($urandom);
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_result", result, res_m);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("handoff_valid", out_valid, 0);
    chk("handoff_in_ready", in_ready, 1);
    chk("handoff_result", result, res_m);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = 8'h00; b = 8'h00; acc_en = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 16'h0000);
    @(negedge clk); rst_n = 1'b1;

    run_op(8'h12, 8'h34, 1'b0, 0, 1'b1, 16'h03A8);
    run_op(8'hFF, 8'hFF, 1'b0, 0, 1'b1, 16'hFE01);
    run_op(8'h00, 8'hA5, 1'b0, 0, 1'b1, 16'h0000);
    run_op(8'h10, 8'h10, 1'b0, 0, 1'b1, 16'h0100);
    run_op(8'h02, 8'h03, 1'b1, 0, 1'b1, 16'h0106);
    run_op(8'hFF, 8'hFF, 1'b0, 0, 1'b1, 16'hFE01);
    run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b1, 16'hFC02);
    run_op(8'h0F, 8'hF0, 1'b0, 10, 1'b1, 16'h0E10);

    // reset during step2 of AB x CD
    @(negedge clk);
    a = 8'hAB; b = 8'hCD; acc_en = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0; #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_result", result, 16'h0000);
    last_m = 16'h0000; res_m = 16'h0000;
    @(negedge clk); rst_n = 1'b1;
    run_op(8'h03, 8'h05, 1'b1, 0, 1'b1, 16'h000F);

    for (int k = 0; k < 40; k++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mul8_seq_ctrl.md
Name: mul8_seq_ctrl

Overview:
- Sequencer that computes an unsigned 8x8 -> 16-bit product with one shared 4x4 combinational array_multiplier instance.
- Issues four nibble-pair passes and shift-accumulates the partial products.
- Optionally accumulates onto the previous result (MAC mode).
- Sits between an upstream operand producer and a downstream consumer, with valid/ready handshakes on both sides.

Parameters:
- None. Operand width is fixed at 8 bits by the 4x4 multiplier core.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b, acc_en are valid
- in_ready  output  1  controller can accept operands
- a  input  8  multiplicand, unsigned
- b  input  8  multiplier, unsigned
- acc_en  input  1  1: add the product to the previously delivered result; 0: fresh product
- out_valid  output  1  result is valid
- out_ready  input  1  consumer accepts the result
- result  output  16  product or accumulated sum
- busy  output  1  high in CALC or DONE

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, busy=0, result=16'h0000.
  - Step counter=0, internal accumulator=0, last-result register=0.
- Registers:
  - a_r, b_r (8 each), step (2 bits), acc (16), last (16), acc_en_r (1).
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture a, b, acc_en into a_r, b_r, acc_en_r.
  - Load acc = acc_en ? last : 0. Set step=0. Go to CALC.
- State CALC: in_ready=0, busy=1. One pass per cycle; the multiplier inputs are muxed from step.
  - step0: a_r[3:0] x b_r[3:0], shift 0.
  - step1: a_r[7:4] x b_r[3:0], shift 4.
  - step2: a_r[3:0] x b_r[7:4], shift 4.
  - step3: a_r[7:4] x b_r[7:4], shift 8.
  - Each edge: acc <= acc + (pp8 << shift), truncated to 16 bits (modulo 2^16, no overflow flag). step increments.
  - On the step3 edge: go to DONE, latch result <= final acc and last <= final acc, assert out_valid.
- Latency:
  - Accept edge E. out_valid goes high after edge E+4 and is visible in the cycle following E+4.
  - Four CALC cycles, fixed regardless of operand values (zero operands are not short-circuited).
- State DONE:
  - out_valid=1; result held stable.
  - On out_ready: out_valid drops at that edge and the state returns to IDLE.
  - in_ready stays 0 in DONE, so no new operand is accepted in the same cycle as result handoff. Minimum issue interval is 6 cycles.
- Backpressure: DONE is held indefinitely while out_ready=0. result and out_valid must not change.
- Inputs ignored when not in IDLE: in_valid, a, b, acc_en have no effect. out_ready is ignored outside DONE.
- result persistence: holds the last delivered value through IDLE and CALC. It is updated only on the step3 edge.
- acc_en with no prior result: after reset, last=0, so acc_en=1 behaves like a fresh multiply.
- Reset mid-operation: rst_n low in any state immediately forces all reset values. The partial accumulation is discarded, and last is cleared to 0.
- Encoding: state encoding is free; the illegal state recovers to IDLE on the next edge.
- Signedness: all arithmetic is unsigned.

Test Plan:
- Reset, then a=8'h12, b=8'h34, acc_en=0, out_ready=1 -> out_valid in the 5th cycle after accept; result=16'h03A8; in_ready back to 1 one cycle after handoff.
- a=8'hFF, b=8'hFF, acc_en=0 -> result=16'hFE01. Then a=8'h00, b=8'hA5 -> result=16'h0000, with identical 4-cycle latency.
- a=8'h10, b=8'h10, acc_en=0 -> 16'h0100. Then a=8'h02, b=8'h03, acc_en=1 -> 16'h0106.
- MAC wrap: 8'hFF x 8'hFF fresh (16'hFE01), then 8'hFF x 8'hFF with acc_en=1 -> 16'hFC02, with no other side effect.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid with 8'h0F x 8'hF0 -> result=16'h0E10 stable, out_valid=1, in_ready=0 throughout.
  - Toggle in_valid with new operands during the stall -> not captured.
  - Release out_ready -> one handoff, then IDLE.
- Pulse rst_n low during CALC step2 of 8'hAB x 8'hCD -> outputs immediately at reset values, last=0.
  - A following 8'h03 x 8'h05 with acc_en=1 -> result=16'h000F.
